image_loader: RTL

- Producer side of the network's pixel input vector.
- Accepts a byte-serial pixel stream over a valid/ready handshake and assembles one full image into an internal frame buffer.
- Presents the buffer as the parallel unpacked array consumed by the FCNN input (`iData`).
- Holds that array stable, with `frame_valid`, until the downstream control acknowledges the frame.

---
 rtl/fcnn_pkg.sv | 12 +
 rtl/image_loader_ctrl.sv | 167 ++++++++++++++++
 rtl/image_loader.sv | 87 ++++++++
 3 files changed

// File: rtl/fcnn_pkg.sv
// Shared types and constants for the FCNN pixel input path.
package fcnn_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int NO_PIXELS  = 784;

  typedef logic [DATA_WIDTH-1:0] pixel_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } loader_state_t;
endpackage

// File: rtl/image_loader_ctrl.sv
// Handshake, pixel index, frame length checks and frame_valid for image_loader.
// IMAGE_LOADER_DBUF_EN adds shadow-bank filling while a frame is held.
module image_loader_ctrl
  import fcnn_pkg::*;
#(
  parameter int NoPixels = NO_PIXELS,
  parameter int CntWidth = $clog2(NoPixels)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  input  logic                s_last,
  input  logic                frame_ack,
  output logic                s_ready,
  output logic                frame_valid,
  output logic [CntWidth-1:0] pix_count,
  output logic                err_short,
  output logic                err_nolast,
  output logic                wr_en,
  output logic [CntWidth-1:0] wr_idx
`ifdef IMAGE_LOADER_DBUF_EN
  ,
  output logic                wr_bank,
  output logic                rd_bank
`endif
);
  localparam logic [CntWidth-1:0] LAST_IDX = CntWidth'(NoPixels - 1);

  loader_state_t       state_r, state_s;
  logic [CntWidth-1:0] cnt_r, cnt_s;
  logic                ready_r, ready_s;
  logic                fv_r, fv_s;
  logic                err_short_r, err_short_s;
  logic                err_nolast_r, err_nolast_s;
  logic                accept_s, is_final_s;
`ifdef IMAGE_LOADER_DBUF_EN
  logic                sel_r, sel_s;
  logic                shadow_full_r, shadow_full_s;
  logic                ack_s;
`endif

  assign accept_s    = s_valid && ready_r;
  assign is_final_s  = (cnt_r == LAST_IDX);
  assign s_ready     = ready_r;
  assign frame_valid = fv_r;
  assign pix_count   = cnt_r;
  assign err_short   = err_short_r;
  assign err_nolast  = err_nolast_r;
  assign wr_en       = accept_s;
  assign wr_idx      = cnt_r;
`ifdef IMAGE_LOADER_DBUF_EN
  assign wr_bank     = ~sel_r;
  assign rd_bank     = sel_r;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= FILL;
      cnt_r         <= '0;
      ready_r       <= 1'b0;
      fv_r          <= 1'b0;
      err_short_r   <= 1'b0;
      err_nolast_r  <= 1'b0;
`ifdef IMAGE_LOADER_DBUF_EN
      sel_r         <= 1'b0;
      shadow_full_r <= 1'b0;
`endif
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      ready_r       <= ready_s;
      fv_r          <= fv_s;
      err_short_r   <= err_short_s;
      err_nolast_r  <= err_nolast_s;
`ifdef IMAGE_LOADER_DBUF_EN
      sel_r         <= sel_s;
      shadow_full_r <= shadow_full_s;
`endif
    end
  end

  // Next-state, counter and error logic
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    ready_s      = ready_r;
    fv_s         = fv_r;
    err_short_s  = 1'b0;
    err_nolast_s = 1'b0;

    // The final index always closes the frame; s_last only decides which error fires.
    if (accept_s) begin
      if (is_final_s) begin
        cnt_s        = '0;
        err_nolast_s = ~s_last;
      end else if (s_last) begin
        cnt_s        = '0;
        err_short_s  = 1'b1;
      end else begin
        cnt_s        = cnt_r + CntWidth'(1);
      end
    end else begin
      cnt_s = cnt_r;
    end

`ifdef IMAGE_LOADER_DBUF_EN
    sel_s         = sel_r;
    shadow_full_s = shadow_full_r;
    ack_s         = frame_ack && (state_r == HOLD);
    // The fill bank is always the one not being presented.
    if (accept_s && is_final_s) begin
      if (!fv_r || ack_s) begin
        sel_s   = ~sel_r;
        fv_s    = 1'b1;
        ready_s = 1'b1;
      end else begin
        shadow_full_s = 1'b1;
        ready_s       = 1'b0;
      end
    end else if (ack_s) begin
      if (shadow_full_r) begin
        sel_s         = ~sel_r;
        shadow_full_s = 1'b0;
        fv_s          = 1'b1;
        ready_s       = 1'b1;
      end else begin
        fv_s    = 1'b0;
        ready_s = 1'b1;
      end
    end else begin
      ready_s = ~shadow_full_r;
    end
    state_s = fv_s ? HOLD : FILL;
`else
    case (state_r)
      FILL: begin
        if (accept_s && is_final_s) begin
          state_s = HOLD;
          fv_s    = 1'b1;
          ready_s = 1'b0;
        end else begin
          state_s = FILL;
          fv_s    = 1'b0;
          ready_s = 1'b1;
        end
      end
      HOLD: begin
        if (frame_ack) begin
          state_s = FILL;
          fv_s    = 1'b0;
          ready_s = 1'b1;
        end else begin
          state_s = HOLD;
          fv_s    = 1'b1;
          ready_s = 1'b0;
        end
      end
      default: begin
        state_s = FILL;
        fv_s    = 1'b0;
        ready_s = 1'b0;
      end
    endcase
`endif
  end
endmodule

// File: rtl/image_loader.sv
// Byte-serial pixel loader presenting a full frame as the FCNN parallel input.
// IMAGE_LOADER_DBUF_EN selects a double-buffered frame store.
module image_loader
  import fcnn_pkg::*;
#(
  parameter int dataWidth = DATA_WIDTH,
  parameter int NoPixels  = NO_PIXELS,
  parameter int CntWidth  = $clog2(NoPixels)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [dataWidth-1:0] s_data,
  input  logic                 s_last,
  output logic                 frame_valid,
  input  logic                 frame_ack,
  output logic [dataWidth-1:0] oData [NoPixels-1:0],
  output logic [CntWidth-1:0]  pix_count,
  output logic                 err_short,
  output logic                 err_nolast
);
  logic                wr_en;
  logic [CntWidth-1:0] wr_idx;
`ifdef IMAGE_LOADER_DBUF_EN
  logic                wr_bank;
  logic                rd_bank;
  logic [dataWidth-1:0] bank0 [NoPixels-1:0];
  logic [dataWidth-1:0] bank1 [NoPixels-1:0];
`endif

  image_loader_ctrl #(
    .NoPixels (NoPixels),
    .CntWidth (CntWidth)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .frame_ack   (frame_ack),
    .s_ready     (s_ready),
    .frame_valid (frame_valid),
    .pix_count   (pix_count),
    .err_short   (err_short),
    .err_nolast  (err_nolast),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx)
`ifdef IMAGE_LOADER_DBUF_EN
    ,
    .wr_bank     (wr_bank),
    .rd_bank     (rd_bank)
`endif
  );

`ifdef IMAGE_LOADER_DBUF_EN
  // Bank writes: the fill bank is never the presented one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NoPixels; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else if (wr_en) begin
      if (wr_bank) bank1[wr_idx] <= s_data;
      else         bank0[wr_idx] <= s_data;
    end
  end

  // Present the active bank
  always_comb begin
    for (int i = 0; i < NoPixels; i++) begin
      oData[i] = rd_bank ? bank1[i] : bank0[i];
    end
  end
`else
  // Single frame buffer, written only by accepted beats
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NoPixels; i++) begin
        oData[i] <= '0;
      end
    end else if (wr_en) begin
      oData[wr_idx] <= s_data;
    end
  end
`endif
endmodule
